mem_stage: RTL

- Memory-access stage of the 5-stage pipeline, between the EX/MEM pipeline register and `MEM2WB`.
- Owns the data memory. Models an access latency of `MEM_LAT` cycles and stalls the upstream pipeline while an access is in progress.
- Forwards writeback controls to `MEM2WB`, inserting a bubble while stalled.
- Produces `ReadData_dmem` for the writeback mux.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_dmem_array.sv | 33 +++
 rtl/mem_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: FSM encoding,
// writeback-mux select encodings and register-index width.
package mem_stage_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned MTR_W     = 2;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } ms_state_e;

    typedef enum logic [MTR_W-1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC  = 2'd2,
        MTR_IN  = 2'd3
    } memtoreg_e;

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Data memory: synchronous write, combinational read, whole-array
// synchronous clear on reset.
module dmem_array
    import mem_stage_pkg::*;
#(
    parameter int unsigned n      = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [n-1:0]      wdata_i,
    output logic [n-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [n-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: multi-cycle data-memory access with
// upstream stall, MEM2WB bubble insertion and a sticky access-conflict flag.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned n       = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [n-1:0]         ALU_out,
    input  logic [n-1:0]         WriteData,
    input  logic [MTR_W-1:0]     MemtoReg,
    input  logic [n-1:0]         inst,
    input  logic [n-1:0]         PC_adder_out,
    input  logic                 IN,
    input  logic                 OUT,
    input  logic                 RegWrite,
    input  logic [REG_IDX_W-1:0] WriteRegister,
    output logic                 mem_stall,
    output logic [n-1:0]         ReadData_dmem,
    output logic [MTR_W-1:0]     MEM_MemtoReg,
    output logic [n-1:0]         MEM_inst,
    output logic [n-1:0]         MEM_PC_adder_out,
    output logic [n-1:0]         MEM_ALU_out,
    output logic                 MEM_IN,
    output logic                 MEM_OUT,
    output logic                 MEM_RegWrite,
    output logic [REG_IDX_W-1:0] MEM_WriteRegister,
    output logic                 mem_err
);

    localparam int unsigned CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned CNT_INIT = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
    localparam bit          SINGLE   = (MEM_LAT == 1);

    ms_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic             req_c;
    logic             both_c;
    logic             last_c;
    logic             stall_c;
    logic             bubble_c;
    logic             we_c;
    logic [n-1:0]     rdata_c;

    assign req_c  = MemRead | MemWrite;
    assign both_c = MemRead & MemWrite;

    // "last" is the single cycle of an access in which data is read or committed
    assign last_c  = (state_q == MS_IDLE) ? (req_c && SINGLE)  : (cnt_q == '0);
    assign stall_c = (state_q == MS_IDLE) ? (req_c && !SINGLE) : (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (req_c && !SINGLE) begin
                        state_q <= MS_BUSY;
                        cnt_q   <= CNT_W'(CNT_INIT);
                    end
                end
                MS_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MS_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= MS_IDLE;
            endcase
            if (last_c && both_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign we_c = ~rst & last_c & MemWrite;

    dmem_array #(
        .n      (n),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_c),
        .addr_i  (ALU_out[ADDR_W-1:0]),
        .wdata_i (WriteData),
        .rdata_o (rdata_c)
    );

    // Load data is visible only in "last" of a pure load
    assign ReadData_dmem = (~rst & last_c & MemRead & ~MemWrite) ? rdata_c : '0;
    assign mem_stall     = ~rst & stall_c;
    assign mem_err       = err_q;

    // Stalled cycles become bubbles in MEM2WB by dropping the side-effect controls
    assign bubble_c          = rst | stall_c;
    assign MEM_RegWrite      = RegWrite & ~bubble_c;
    assign MEM_IN            = IN & ~bubble_c;
    assign MEM_OUT           = OUT & ~bubble_c;
    assign MEM_MemtoReg      = MemtoReg;
    assign MEM_inst          = inst;
    assign MEM_PC_adder_out  = PC_adder_out;
    assign MEM_ALU_out       = ALU_out;
    assign MEM_WriteRegister = WriteRegister;

endmodule
